// File: rtl/add_sub_pipe_pkg.sv
// Shared configuration helpers and the flag bundle for the pipelined adder/subtractor.
package add_sub_pkg;

    // True when the carry chain splits into equal, non-empty slices.
    function automatic bit cfg_ok(input int width, input int stages);
        return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
    endfunction

    function automatic int slice_width(input int width, input int stages);
        return (stages >= 1) ? (width / stages) : width;
    endfunction

    typedef struct packed {
        logic co;
        logic ovf;
        logic zero;
    } flags_t;

endpackage

// File: rtl/add_sub_pipe_if.sv
// Operand/result stream between a source, add_sub_pipe and a back-pressuring consumer.
interface add_sub_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             sub;
    logic [TAG_W-1:0] tag;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;
    logic             zero;
    logic [TAG_W-1:0] tag_out;

    modport slave (
        input  in_valid, a, b, ci, sub, tag, out_ready,
        output in_ready, out_valid, s, co, ovf, zero, tag_out
    );

    modport master (
        output in_valid, a, b, ci, sub, tag, out_ready,
        input  in_ready, out_valid, s, co, ovf, zero, tag_out
    );
endinterface

// File: rtl/add_sub_pipe_slice.sv
// Combinational CW-bit carry slice; one instance per pipeline stage.
module add_sub_slice #(
    parameter int CW = 8
) (
    input  logic [CW-1:0] x,
    input  logic [CW-1:0] y,
    input  logic          cin,
    output logic [CW-1:0] sum,
    output logic          cout
);
    assign {cout, sum} = {1'b0, x} + {1'b0, y} + {{CW{1'b0}}, cin};
endmodule

// File: rtl/add_sub_pipe.sv
// Pipelined add/sub: one carry slice per stage, global stall on output back-pressure.
module add_sub_pipe
    import add_sub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int TAG_W  = 4
) (
    input  logic          clk,
    input  logic          rst,
    add_sub_pipe_if.slave io
);
    localparam int CW   = slice_width(WIDTH, STAGES);
    localparam int LAST = STAGES - 1;

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_check
        $error("add_sub_pipe: WIDTH must be a non-zero multiple of STAGES");
    end

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             cin0;
    flags_t           flags;

    // Subtract runs as a + ~b + ~ci, so both b and the carry-in are inverted up front.
    assign b_eff   = io.b ^ {WIDTH{io.sub}};
    assign cin0    = io.ci ^ io.sub;
    assign advance = !g_st[LAST].v_q || io.out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int AW = WIDTH - k * CW;

        logic [AW-1:0]         a_in;
        logic [AW-1:0]         b_in;
        logic                  c_in;
        logic                  v_in;
        logic                  sub_in;
        logic [TAG_W-1:0]      tag_in;
        logic [(k+1)*CW-1:0]   res_d;
        logic [(k+1)*CW-1:0]   res_q;
        logic [CW-1:0]         sum;
        logic                  cout;
        logic                  v_q;
        logic [TAG_W-1:0]      tag_q;

        if (k == 0) begin : g_src
            assign a_in   = io.a;
            assign b_in   = b_eff;
            assign c_in   = cin0;
            assign v_in   = io.in_valid;
            assign sub_in = io.sub;
            assign tag_in = io.tag;
            assign res_d  = sum;
        end else begin : g_src
            assign a_in   = g_st[k-1].g_fwd.a_q;
            assign b_in   = g_st[k-1].g_fwd.b_q;
            assign c_in   = g_st[k-1].g_fwd.c_q;
            assign v_in   = g_st[k-1].v_q;
            assign sub_in = g_st[k-1].g_fwd.sub_q;
            assign tag_in = g_st[k-1].tag_q;
            assign res_d  = {sum, g_st[k-1].res_q};
        end

        add_sub_slice #(.CW(CW)) u_slice (
            .x   (a_in[CW-1:0]),
            .y   (b_in[CW-1:0]),
            .cin (c_in),
            .sum (sum),
            .cout(cout)
        );

        // NOTE: non-blocking assignments let every stage capture its predecessor's pre-edge value.
        // NOTE: data registers are reset along with the valid bits so s/co/ovf/tag_out read 0 after reset.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q   <= 1'b0;
                tag_q <= '0;
                res_q <= '0;
            end else if (advance) begin
                v_q   <= v_in;
                tag_q <= tag_in;
                res_q <= res_d;
            end
        end

        if (k < LAST) begin : g_fwd
            logic [AW-CW-1:0] a_q;
            logic [AW-CW-1:0] b_q;
            logic             c_q;
            logic             sub_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    c_q   <= 1'b0;
                    sub_q <= 1'b0;
                end else if (advance) begin
                    a_q   <= a_in[AW-1:CW];
                    b_q   <= b_in[AW-1:CW];
                    c_q   <= cout;
                    sub_q <= sub_in;
                end
            end
        end else begin : g_last
            logic co_q;
            logic ovf_q;

            // The operand MSBs live in this final slice, so overflow is resolved here.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    co_q  <= 1'b0;
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    co_q  <= cout ^ sub_in;
                    ovf_q <= (a_in[CW-1] == b_in[CW-1]) && (sum[CW-1] != a_in[CW-1]);
                end
            end
        end
    end

    assign flags.co   = g_st[LAST].g_last.co_q;
    assign flags.ovf  = g_st[LAST].g_last.ovf_q;
    assign flags.zero = (g_st[LAST].res_q == '0);

    assign io.in_ready  = advance;
    assign io.out_valid = g_st[LAST].v_q;
    assign io.s         = g_st[LAST].res_q;
    assign io.co        = flags.co;
    assign io.ovf       = flags.ovf;
    assign io.zero      = flags.zero;
    assign io.tag_out   = g_st[LAST].tag_q;

endmodule
